// File: rtl/systolic_sequencer_if.sv
// Bundle between the job/stream source, the sequencer and the 2x2 systolic array.
// The slave modport is the sequencer's view; the master modport is the environment's.
interface systolic_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_VECS   = 16
);
  localparam int CW = $clog2(MAX_VECS + 1);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DATA_WIDTH-1:0] cfg_w00;
  logic [DATA_WIDTH-1:0] cfg_w01;
  logic [DATA_WIDTH-1:0] cfg_w10;
  logic [DATA_WIDTH-1:0] cfg_w11;
  logic [CW-1:0]         cfg_count;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_x0;
  logic [DATA_WIDTH-1:0] in_x1;

  logic                  arr_load_weights;
  logic                  arr_start;
  logic [DATA_WIDTH-1:0] arr_w00;
  logic [DATA_WIDTH-1:0] arr_w01;
  logic [DATA_WIDTH-1:0] arr_w10;
  logic [DATA_WIDTH-1:0] arr_w11;
  logic [DATA_WIDTH-1:0] arr_x0;
  logic [DATA_WIDTH-1:0] arr_x1;
  logic [DATA_WIDTH-1:0] arr_y0;
  logic [DATA_WIDTH-1:0] arr_y1;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_y0;
  logic [DATA_WIDTH-1:0] out_y1;
  logic                  done;

  modport slave (
    input  cfg_valid, cfg_w00, cfg_w01, cfg_w10, cfg_w11, cfg_count,
    input  in_valid, in_x0, in_x1,
    input  arr_y0, arr_y1,
    output cfg_ready, in_ready,
    output arr_load_weights, arr_start,
    output arr_w00, arr_w01, arr_w10, arr_w11, arr_x0, arr_x1,
    output out_valid, out_y0, out_y1, done
  );

  modport master (
    output cfg_valid, cfg_w00, cfg_w01, cfg_w10, cfg_w11, cfg_count,
    output in_valid, in_x0, in_x1,
    output arr_y0, arr_y1,
    input  cfg_ready, in_ready,
    input  arr_load_weights, arr_start,
    input  arr_w00, arr_w01, arr_w10, arr_w11, arr_x0, arr_x1,
    input  out_valid, out_y0, out_y1, done
  );
endinterface

// File: rtl/systolic_sequencer.sv
// Job sequencer for the 2x2 weight-stationary array: loads weights, skews lane 1
// by one cycle, and realigns the staggered y0/y1 outputs into one result strobe.
//
// state   | meaning
// IDLE    | waiting for a job, cfg_ready high
// LOAD    | one-cycle weight load pulse to the array
// FEED    | accepting input vectors until the job total is reached
// DRAIN   | waiting for the last in-flight result to be issued
// DONE    | one-cycle end-of-job pulse
module systolic_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_VECS   = 16
) (
  input logic            clk,
  input logic            reset,
  systolic_sequencer_if.slave bus
);
  localparam int            CW      = $clog2(MAX_VECS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_VECS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]         r_total, r_acc_cnt, w_cnt_clamped;
  logic                  w_cfg_ready, w_in_ready, w_load, w_start, w_done;
  logic                  w_cfg_fire, w_in_fire;
  logic [DATA_WIDTH-1:0] r_w00, r_w01, r_w10, r_w11;
  logic [DATA_WIDTH-1:0] r_x0, r_x1_d, r_x1;
  logic [3:0]            r_tag;
  logic [DATA_WIDTH-1:0] r_y0_hold, r_out_y0, r_out_y1;
  logic                  r_out_valid;

  assign w_cnt_clamped = (bus.cfg_count > MAX_CNT) ? MAX_CNT : bus.cfg_count;
  assign w_cfg_fire    = bus.cfg_valid && w_cfg_ready;
  assign w_in_fire     = bus.in_valid && w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_ready = 1'b0;
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          w_state_nxt = (w_cnt_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_FEED;
      end
      S_FEED: begin
        w_in_ready = 1'b1;
        w_start    = 1'b1;
        if (bus.in_valid && (r_acc_cnt + CW'(1) == r_total)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_start = 1'b1;
        // the strobe in flight with an empty tag pipe is the job's last result
        if (r_out_valid && (r_tag == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_total   <= '0;
      r_acc_cnt <= '0;
      r_w00     <= '0;
      r_w01     <= '0;
      r_w10     <= '0;
      r_w11     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cfg_fire) begin
        r_w00     <= bus.cfg_w00;
        r_w01     <= bus.cfg_w01;
        r_w10     <= bus.cfg_w10;
        r_w11     <= bus.cfg_w11;
        r_total   <= w_cnt_clamped;
        r_acc_cnt <= '0;
      end else if (w_in_fire) begin
        r_acc_cnt <= r_acc_cnt + CW'(1);
      end
    end
  end

  // Lane 1 trails lane 0 by one cycle; bubbles push zeros and no tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x0        <= '0;
      r_x1_d      <= '0;
      r_x1        <= '0;
      r_tag       <= '0;
      r_y0_hold   <= '0;
      r_out_valid <= 1'b0;
      r_out_y0    <= '0;
      r_out_y1    <= '0;
    end else begin
      r_x0        <= w_in_fire ? bus.in_x0 : '0;
      r_x1_d      <= w_in_fire ? bus.in_x1 : '0;
      r_x1        <= r_x1_d;
      r_tag       <= {r_tag[2:0], w_in_fire};
      r_out_valid <= r_tag[3];
      if (r_tag[2]) begin
        r_y0_hold <= bus.arr_y0;
      end
      if (r_tag[3]) begin
        r_out_y0 <= r_y0_hold;
        r_out_y1 <= bus.arr_y1;
      end
    end
  end

  assign bus.cfg_ready        = w_cfg_ready;
  assign bus.in_ready         = w_in_ready;
  assign bus.arr_load_weights = w_load;
  assign bus.arr_start        = w_start;
  assign bus.done             = w_done;
  assign bus.arr_w00          = r_w00;
  assign bus.arr_w01          = r_w01;
  assign bus.arr_w10          = r_w10;
  assign bus.arr_w11          = r_w11;
  assign bus.arr_x0           = r_x0;
  assign bus.arr_x1           = r_x1;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_y0           = r_out_y0;
  assign bus.out_y1           = r_out_y1;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: behavioural 2x2 array, table-driven single jobs,
// hand-written corner sequences and randomized jobs against a result scoreboard.
module tb_systolic_sequencer;
  localparam int DW = 8;
  localparam int MV = 16;
  localparam int CW = $clog2(MV + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  systolic_sequencer_if #(.DATA_WIDTH(DW), .MAX_VECS(MV)) bif ();
  systolic_sequencer #(.DATA_WIDTH(DW), .MAX_VECS(MV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural array: y0 two cycles after its x0, y1 three cycles after.
  logic [DW-1:0] h_x0_1 = '0, h_x0_2 = '0, h_x0_3 = '0, h_x1_1 = '0, h_x1_2 = '0;
  always @(posedge clk) begin
    h_x0_1 <= bif.arr_x0;
    h_x0_2 <= h_x0_1;
    h_x0_3 <= h_x0_2;
    h_x1_1 <= bif.arr_x1;
    h_x1_2 <= h_x1_1;
  end
  assign bif.arr_y0 = bif.arr_w00 * h_x0_2 + bif.arr_w10 * h_x1_1;
  assign bif.arr_y1 = bif.arr_w01 * h_x0_3 + bif.arr_w11 * h_x1_2;

  function automatic int mac(input int wa, input int xa, input int wb, input int xb);
    return (wa * xa + wb * xb) % 256;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {int cyc; int y0; int y1;} exp_t;
  exp_t q[$];
  exp_t out_log[$];
  int mw00, mw01, mw10, mw11;
  int job_acc = 0, last_acc = 0, n_out = 0, n_done = 0;

  // Scoreboard: every accepted vector must come out exactly five cycles later.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (bif.cfg_valid && bif.cfg_ready) begin
        mw00 = bif.cfg_w00; mw01 = bif.cfg_w01; mw10 = bif.cfg_w10; mw11 = bif.cfg_w11;
        job_acc = 0;
      end
      if (bif.in_valid && bif.in_ready) begin
        q.push_back('{cyc + 5, mac(mw00, bif.in_x0, mw10, bif.in_x1),
                      mac(mw01, bif.in_x0, mw11, bif.in_x1)});
        job_acc++;
        last_acc = cyc;
      end
      if (bif.out_valid) begin
        bit has;
        exp_t e;
        n_out++;
        out_log.push_back('{cyc, int'(bif.out_y0), int'(bif.out_y1)});
        has = (q.size() > 0);
        check("out_has_expected", has, 1);
        if (has) begin
          e = q.pop_front();
          check("out_latency_cycle", cyc, e.cyc);
          check("out_y0", bif.out_y0, e.y0);
          check("out_y1", bif.out_y1, e.y1);
        end
      end
      if (bif.done) n_done++;
    end
  end

  task automatic start_job(input int w00, input int w01, input int w10, input int w11,
                           input int cnt, output int c);
    c = -1;
    bif.cfg_w00 = DW'(w00); bif.cfg_w01 = DW'(w01);
    bif.cfg_w10 = DW'(w10); bif.cfg_w11 = DW'(w11);
    bif.cfg_count = CW'(cnt);
    bif.cfg_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bif.cfg_ready) begin c = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bif.cfg_valid = 1'b0;
    check("cfg_accepted", c >= 0, 1);
  endtask

  task automatic send_vec(input int x0, input int x1, output int a);
    a = -1;
    bif.in_valid = 1'b1; bif.in_x0 = DW'(x0); bif.in_x1 = DW'(x1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bif.in_ready) begin a = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    check("vec_accepted", a >= 0, 1);
  endtask

  task automatic wait_done(input int exp_cyc, input string nm);
    int d = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bif.done) begin d = cyc; break; end
    end
    check({nm, "_done_cycle"}, d, exp_cyc);
    @(negedge clk);
    check({nm, "_done_one_cycle"}, bif.done, 0);
    check({nm, "_cfg_ready_back"}, bif.cfg_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_cfg_ready"}, bif.cfg_ready, 1);
    check({nm, "_ctrl"}, {bif.in_ready, bif.arr_load_weights, bif.arr_start,
                          bif.out_valid, bif.done}, 0);
    check({nm, "_arr_w"}, {bif.arr_w00, bif.arr_w01, bif.arr_w10, bif.arr_w11}, 0);
    check({nm, "_arr_x"}, {bif.arr_x0, bif.arr_x1}, 0);
    check({nm, "_out_y"}, {bif.out_y0, bif.out_y1}, 0);
  endtask

  typedef struct {int w00, w01, w10, w11, x0, x1, y0, y1;} vec_t;
  vec_t tbl[7];

  task automatic run_single(input vec_t e, input string nm);
    int c, a, n0;
    n0 = n_out;
    start_job(e.w00, e.w01, e.w10, e.w11, 1, c);
    @(negedge clk);
    check({nm, "_load_pulse"}, bif.arr_load_weights, 1);
    check({nm, "_load_in_ready"}, bif.in_ready, 0);
    check({nm, "_load_cfg_ready"}, bif.cfg_ready, 0);
    @(posedge clk); #1;
    send_vec(e.x0, e.x1, a);
    check({nm, "_first_accept"}, a, c + 2);
    wait_done(a + 6, nm);
    check({nm, "_n_out"}, n_out - n0, 1);
    check({nm, "_y0"}, out_log[$].y0, e.y0);
    check({nm, "_y1"}, out_log[$].y1, e.y1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, a, nacc, n0, d0, cnt, ecnt;
    int acc_cyc[4];
    int bb_y0[4] = '{1, 3, 8, 10};
    int bb_y1[4] = '{2, 4, 12, 18};
    bit bub[6] = '{1, 0, 0, 1, 0, 1};

    tbl[0] = '{1, 2, 3, 4, 5, 6, 23, 34};
    tbl[1] = '{16, 16, 16, 16, 16, 16, 0, 0};
    tbl[2] = '{15, 15, 15, 15, 10, 10, 44, 44};
    tbl[3] = '{0, 0, 0, 0, 255, 255, 0, 0};
    tbl[4] = '{255, 1, 1, 255, 1, 1, 0, 0};
    tbl[5] = '{2, 3, 5, 7, 9, 11, 73, 104};
    tbl[6] = '{200, 100, 50, 25, 3, 4, 32, 144};

    bif.cfg_valid = 1'b0; bif.cfg_count = '0;
    bif.cfg_w00 = '0; bif.cfg_w01 = '0; bif.cfg_w10 = '0; bif.cfg_w11 = '0;
    bif.in_valid = 1'b0; bif.in_x0 = '0; bif.in_x1 = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;

    foreach (tbl[i]) run_single(tbl[i], $sformatf("single%0d", i));

    // back-to-back stream of four vectors
    out_log.delete();
    start_job(1, 2, 3, 4, 4, c);
    send_vec(1, 0, acc_cyc[0]);
    send_vec(0, 1, acc_cyc[1]);
    send_vec(2, 2, acc_cyc[2]);
    send_vec(7, 1, acc_cyc[3]);
    check("b2b_first_accept", acc_cyc[0], c + 2);
    for (int i = 1; i < 4; i++) check("b2b_consecutive", acc_cyc[i], acc_cyc[0] + i);
    wait_done(acc_cyc[3] + 6, "b2b");
    check("b2b_out_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check("b2b_y0", out_log[i].y0, bb_y0[i]);
      check("b2b_y1", out_log[i].y1, bb_y1[i]);
      check("b2b_out_cycle", out_log[i].cyc, acc_cyc[0] + 5 + i);
    end

    // bubbles between accepted vectors
    n0 = n_out; nacc = 0;
    start_job(5, 6, 7, 8, 3, c);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      bif.in_valid = bub[i];
      bif.in_x0 = DW'(40 * i + 3); bif.in_x1 = DW'(250 - 17 * i);
      @(negedge clk);
      if (bif.in_valid && bif.in_ready) nacc++;
      @(posedge clk); #1;
    end
    bif.in_valid = 1'b0;
    check("bubble_accepts", nacc, 3);
    wait_done(last_acc + 6, "bubble");
    check("bubble_n_out", n_out - n0, 3);

    // reset while two results are in flight
    start_job(9, 8, 7, 6, 2, c);
    send_vec(1, 2, a);
    send_vec(3, 4, a);
    @(negedge clk);
    check("rstmid_in_drain_start", bif.arr_start, 1);
    check("rstmid_in_drain_in_ready", bif.in_ready, 0);
    n0 = n_out; d0 = n_done;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rstmid");
    repeat (12) @(posedge clk);
    #1;
    check("rstmid_no_out", n_out - n0, 0);
    check("rstmid_no_done", n_done - d0, 0);
    run_single(tbl[0], "after_rst");

    // zero-count job
    n0 = n_out;
    start_job(1, 1, 1, 1, 0, c);
    @(negedge clk);
    check("zero_done", bif.done, 1);
    check("zero_no_activity", {bif.arr_load_weights, bif.arr_start, bif.in_ready}, 0);
    @(negedge clk);
    check("zero_done_one_cycle", bif.done, 0);
    check("zero_cfg_ready", bif.cfg_ready, 1);
    check("zero_no_out", n_out - n0, 0);
    @(posedge clk); #1;

    // clamp: in_valid and a competing cfg_valid held high throughout
    nacc = 0;
    start_job(1, 0, 0, 1, MV + 5, c);
    @(posedge clk); #1;
    bif.in_valid = 1'b1;
    bif.cfg_valid = 1'b1;
    bif.cfg_w00 = 8'd77;
    for (int i = 0; i < 100; i++) begin
      bif.in_x0 = DW'($urandom); bif.in_x1 = DW'($urandom);
      @(negedge clk);
      if (!bif.in_ready) break;
      nacc++;
      @(posedge clk); #1;
    end
    check("clamp_cfg_ignored", bif.cfg_ready, 0);
    @(posedge clk); #1;
    bif.cfg_valid = 1'b0;
    wait_done(last_acc + 6, "clamp");
    bif.in_valid = 1'b0;
    check("clamp_accepts", nacc, MV);
    check("clamp_job_acc", job_acc, MV);

    // randomized jobs against the scoreboard
    for (int j = 0; j < 25; j++) begin
      cnt  = $urandom_range(0, MV + 3);
      ecnt = (cnt > MV) ? MV : cnt;
      n0   = n_out;
      start_job($urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), cnt, c);
      if (ecnt == 0) begin
        wait_done(c + 1, "rnd_zero");
      end else begin
        @(posedge clk); #1;
        for (int i = 0; i < 500; i++) begin
          bif.in_valid = ($urandom_range(0, 99) < 65);
          bif.in_x0 = DW'($urandom); bif.in_x1 = DW'($urandom);
          @(negedge clk);
          if (!bif.in_ready) break;
          @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
        @(posedge clk); #1;
        wait_done(last_acc + 6, "rnd");
      end
      check("rnd_job_acc", job_acc, ecnt);
      check("rnd_n_out", n_out - n0, ecnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Control and data-alignment stage wrapped around the 2x2 weight-stationary systolic array. Accepts one weight configuration plus a stream of `cfg_count` input vectors, then drives the array's weight-load and start controls. It applies the required one-cycle skew to the second input lane, realigns the two staggered array outputs into one result vector, and signals completion. It sits directly upstream of the array, feeding it, and directly downstream of it, consuming its results.

## Interface
- `DATA_WIDTH`, default 8: width of weights, inputs and results.
- `MAX_VECS`, default 16: maximum vectors per job. `CW = $clog2(MAX_VECS+1)`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `cfg_valid` / `cfg_ready`  in / out  1 / 1  job handshake.
- `cfg_w00`, `cfg_w01`, `cfg_w10`, `cfg_w11`  in  DATA_WIDTH each  weights.
- `cfg_count`  in  CW  number of vectors in the job; values above MAX_VECS are clamped to MAX_VECS.
- `in_valid` / `in_ready`  in / out  1 / 1  vector handshake.
- `in_x0`, `in_x1`  in  DATA_WIDTH each  input vector.
- `arr_load_weights`, `arr_start`  out  1 each  array controls.
- `arr_w00`..`arr_w11`, `arr_x0`, `arr_x1`  out  DATA_WIDTH each  array operands.
- `arr_y0`, `arr_y1`  in  DATA_WIDTH each  array results.
- `out_valid`  out  1  one-cycle result strobe; there is no backpressure.
- `out_y0`, `out_y1`  out  DATA_WIDTH each  aligned result.
- `done`  out  1  one-cycle end-of-job pulse.

## Operation
- FSM states: IDLE, LOAD, FEED, DRAIN, DONE.
- **IDLE**
  - `cfg_ready` = 1.
  - On `cfg_valid`: latch the weights into `arr_w*`, latch the clamped count, and go to LOAD.
  - If the latched count is 0, go directly to DONE instead.
- **LOAD**
  - `arr_load_weights` = 1 for exactly one cycle.
  - Go to FEED.
- **FEED**
  - `in_ready` = 1 and `arr_start` = 1.
  - Each accepted vector (`in_valid & in_ready`) increments the accepted count.
  - When the count reaches the job total, go to DRAIN in the same cycle; `in_ready` drops the next cycle.
- **DRAIN**
  - `in_ready` = 0 and `arr_start` = 1.
  - Leave for DONE once the last `out_valid` has been issued.
- **DONE**
  - `done` = 1 for one cycle, then return to IDLE.
  - `cfg_ready` is 0 in every state except IDLE.
- **Skew**
  - Vector k accepted in cycle A gives `arr_x0` = x0 in cycle A+1 and `arr_x1` = x1 in cycle A+2, both through registers.
  - In a cycle with no accept, the lane registers load 0 (bubble).
- **Alignment**
  - The array presents y0 of a vector 2 cycles after its `arr_x0` cycle and y1 3 cycles after it.
  - A 4-deep valid-tag shift register tracks vectors through the array.
  - `arr_y0` is captured into a hold register at tag stage 2.
  - At tag stage 3, `out_y0` <= hold and `out_y1` <= `arr_y1`, and `out_valid` <= 1.
- **Bubbles**
  - Bubbles carry no tag and never produce `out_valid`.
  - Results stay in acceptance order.
- **Arithmetic**
  - Results are what the array produces: y0 = w00·x0 + w10·x1 and y1 = w01·x0 + w11·x1, truncated mod 2^DATA_WIDTH.
  - The sequencer passes them through unmodified.
- **Reset**
  - Reset in any state, mid-job included, returns the FSM to IDLE and zeroes all counters, tags, hold and skew registers.
  - In-flight results are discarded; no `out_valid` or `done` follows.

## Timing
- Reset values:
  - `cfg_ready` = 1 (IDLE).
  - All other outputs 0: `in_ready`, `arr_load_weights`, `arr_start`, `arr_w*`, `arr_x*`, `out_valid`, `out_y*`, `done`.
- Job start: cfg accepted in cycle C → `arr_load_weights` in cycle C+1 → `in_ready` first high in cycle C+2.
- Latency: a vector accepted in cycle A produces `out_valid` in cycle A+5; the block sustains one vector per cycle.
- Completion: if the last vector is accepted in cycle L, the last `out_valid` is in cycle L+5, `done` in L+6, and `cfg_ready` is high again in L+7.
- Zero-count job: cfg accepted in cycle C → `done` in C+1; no load, no start.
- `in_valid` is ignored outside FEED.
- `cfg_valid` is ignored outside IDLE.

## Test plan
- **Single vector:** weights (w00,w01,w10,w11) = (1,2,3,4), count = 1, x = (5,6) → `arr_load_weights` pulse, `out_y0` = 23, `out_y1` = 34, `out_valid` 5 cycles after the accept, `done` the cycle after.
- **Back-to-back stream:** same weights, count = 4, x = (1,0), (0,1), (2,2), (7,1) accepted on consecutive cycles → results (1,2), (3,4), (8,12), (10,18) on 4 consecutive `out_valid` cycles.
- **Bubbles:** count = 3, `in_valid` toggled 1,0,0,1,0,1 → exactly 3 `out_valid` pulses, each 5 cycles after its accept, with correct values and none from bubbles.
- **Wrap-around:** all weights 16, x = (16,16) → `out_y0` = 0, `out_y1` = 0; weights 15, x = (10,10) → 300 mod 256 = 44.
- **Reset mid-job:** assert reset during DRAIN with 2 results in flight → no further `out_valid`/`done`, all outputs at reset values, `cfg_ready` = 1; a following job with count = 1 completes correctly.
- **Zero-count and clamp:** count = 0 → `done` 1 cycle after the cfg accept and no array activity; count = MAX_VECS+5 → exactly MAX_VECS vectors accepted before `in_ready` drops.
